// File: rtl/list_pkg.sv
// list_pkg: linked-list layout shared by the list writer and list reader.
//   list_state_t - writer FSM states
//   LINK_OFS     - word offset of the link within a node
//   VAL_OFS      - word offset of the value within a node
//   NODE_STRIDE  - words per node
//   NULL_PTR     - link value that terminates a list
package list_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WR_VAL,
        ST_WR_LINK,
        ST_DONE
    } list_state_t;

    localparam int unsigned LINK_OFS    = 0;
    localparam int unsigned VAL_OFS     = 1;
    localparam int unsigned NODE_STRIDE = 2;
    localparam int unsigned NULL_PTR    = 0;

endpackage

// File: rtl/list_writer.sv
// list_writer: builds a null-terminated linked list in an external
// word-addressed RAM from a stream of values. Each node is a link word at
// base p and a value word at p+1. Nodes are allocated from address 0.
//   clk, rst             - clock, synchronous active-high reset
//   start                - begin a new list (sampled only when idle)
//   in_valid/in_data/in_last, in_ready - value stream handshake
//   mem_we/mem_addr/mem_wdata          - RAM write port
//   busy, done           - activity flag, one-cycle termination pulse
//   node_count, sum      - nodes written and their wrapping sum
//   overflow             - list truncated at RAM capacity (sticky)
module list_writer
    import list_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] node_count,
    output logic [DATA_W-1:0] sum,
    output logic              overflow
);

    // Highest node base that still leaves room for its value word.
    localparam logic [ADDR_W-1:0] MAX_P = {{(ADDR_W-1){1'b1}}, 1'b0};

    list_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [ADDR_W-1:0] next_ptr;
    logic              terminate;

    always_comb begin
        next_ptr  = ptr + ADDR_W'(NODE_STRIDE);
        terminate = last_q || (ptr == MAX_P);
    end

    // Memory outputs are loaded on the edge entering the write states so
    // they are valid in the same cycle as mem_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            node_count <= '0;
            sum        <= '0;
            overflow   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr        <= '0;
                        node_count <= '0;
                        sum        <= '0;
                        overflow   <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        data_q    <= in_data;
                        last_q    <= in_last;
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr + ADDR_W'(VAL_OFS);
                        mem_wdata <= in_data;
                        state     <= ST_WR_VAL;
                    end
                end
                ST_WR_VAL: begin
                    sum       <= sum + data_q;
                    mem_addr  <= ptr + ADDR_W'(LINK_OFS);
                    mem_wdata <= terminate ? DATA_W'(NULL_PTR) : DATA_W'(next_ptr);
                    state     <= ST_WR_LINK;
                end
                ST_WR_LINK: begin
                    node_count <= node_count + 1'b1;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                    if (terminate) begin
                        // Not last means the RAM ran out of node slots.
                        overflow <= !last_q;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        ptr      <= next_ptr;
                        in_ready <= 1'b1;
                        state    <= ST_ACCEPT;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
